mac_dot_seq: RTL
================

# mac_dot_seq

Sequencer that computes a signed dot product of two length-N int8 vectors by driving the shared signed 8-bit MAC (26-bit signed accumulator). It sits between two synchronous-read vector memories (A and B) and the MAC, issuing addresses, feeding operands, clearing the accumulator and capturing the final sum. A start/done handshake controls it.

## Interface
- ADDR_W, 6, memory address width; maximum vector length is 2^ADDR_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running job.
- len  in  ADDR_W+1  element count N, 0..2^ADDR_W; latched on start.
- base_a, base_b  in  ADDR_W each  start addresses; latched on start.
- addr_a, addr_b  out  ADDR_W each  memory read addresses.
- ren  out  1  memory read enable; data returns exactly 1 cycle later.
- rdata_a, rdata_b  in  8 each  signed memory read data.
- mac_in1, mac_in2  out  8 each  signed MAC operands.
- mac_clr  out  1  high: MAC acc becomes 0 at the next edge; low: MAC acc <= acc + in1*in2.
- mac_acc  in  26  signed MAC accumulator value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  26  signed dot product; holds until the next capture.

## Operation
- States: IDLE, CLR, READ, DRAIN, CAPT, DONE.
- IDLE: start=1 latches len, base_a and base_b, clears index k, and moves to CLR.
- CLR: mac_clr=1 and operands 0.
  - If N>=1: ren=1, addr = base+0, k=1.
  - Next state: READ if N>=2, DRAIN if N==1, CAPT if N==0.
- READ: ren=1, addr = base+k, mac_in1/mac_in2 = rdata_a/rdata_b (element k-1), k increments. Moves to DRAIN after issuing address N-1.
- DRAIN: ren=0, operands = data of element N-1. Moves to CAPT.
- CAPT: result <= mac_acc. Moves to DONE.
- DONE: done=1 for one cycle. Moves to IDLE.
- Outside READ and DRAIN, mac_in1 and mac_in2 are 0, so the accumulator holds.
- Outside CLR, mac_clr=0.
- Address arithmetic is modulo 2^ADDR_W, so base+k wraps silently.
- Width: |product| <= 16384 and N <= 64 by default, so the sum is at most 2^20 and fits in 26 bits signed. No saturation logic.
- start while busy is ignored. No queueing.
- abort=1 in any non-IDLE state forces IDLE at the next edge:
  - done is not asserted and result is unchanged.
  - ren, mac_clr and operands drop to 0 in the cycle after abort.
  - abort beats start when both are high in the same cycle.
- Reset value of every output is 0 and the state is IDLE. Reset mid-job discards the job.

## Timing
- Cycle 1 is the first cycle after the edge that accepts start.
- N>=1: CLR in cycle 1, READ in cycles 2..N, DRAIN in cycle N+1, CAPT in cycle N+2, done in cycle N+3.
- N=0: CLR, CAPT, DONE; done in cycle 3 with result 0.
- busy rises in cycle 1 and falls in the cycle after DONE.
- A new start is accepted in the first IDLE cycle, which gives back-to-back jobs.
- Memory read latency is fixed at 1 cycle. Operands go to the MAC combinationally from rdata. The MAC updates at the end of the cycle in which it receives the operands.

## Test plan
- N=4, A={1,2,3,4}, B={5,6,7,8} -> done in cycle 7, result=70, busy high in cycles 1..7, addr sequence 0,1,2,3.
- N=64, A all -128, B all -128 -> result=1048576, no overflow, done in cycle 67.
- N=3, base_a=62 with ADDR_W=6, A[62]=-3, A[63]=4, A[0]=-5, B all 2 -> addr_a wraps 62,63,0; result=-8.
- N=0 -> no ren pulses, done in cycle 3, result=0. Then N=1 with A=-7, B=9 started the cycle after done -> result=-63.
- Abort in cycle 3 of an N=8 job -> IDLE next cycle, no done pulse, result keeps its previous value. A following N=2 job {3,3}·{-1,-1} returns -6, which proves the accumulator was cleared.
- rst_n low during READ -> all outputs 0 immediately. After release the next job returns the correct sum. start pulses while busy do not restart the job.

Source files
------------

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams two int8 vectors from synchronous-read memories
// into an external signed MAC, then captures the accumulated sum.
module mac_dot_seq #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     len,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]   addr_b,
    output logic                ren,
    input  logic signed [7:0]   rdata_a,
    input  logic signed [7:0]   rdata_b,
    output logic signed [7:0]   mac_in1,
    output logic signed [7:0]   mac_in2,
    output logic                mac_clr,
    input  logic signed [25:0]  mac_acc,
    output logic                busy,
    output logic                done,
    output logic signed [25:0]  result
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClr   = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StCapt  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    localparam logic [ADDR_W:0] LenZero = '0;
    localparam logic [ADDR_W:0] LenOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LenTwo  = LenOne + LenOne;

    logic [2:0]               state_q, state_d;
    logic [ADDR_W:0]          k_q, k_d;
    logic [ADDR_W:0]          len_q, len_d;
    logic [ADDR_W-1:0]        base_a_q, base_a_d;
    logic [ADDR_W-1:0]        base_b_q, base_b_d;
    logic signed [25:0]       result_q, result_d;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        len_d    = len_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        result_d = result_q;
        ren      = 1'b0;
        addr_a   = '0;
        addr_b   = '0;
        mac_in1  = '0;
        mac_in2  = '0;
        mac_clr  = 1'b0;
        done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = len;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    k_d      = '0;
                    state_d  = StClr;
                end
            end
            StClr: begin
                mac_clr = 1'b1;
                if (len_q != LenZero) begin
                    ren    = 1'b1;
                    addr_a = base_a_q;
                    addr_b = base_b_q;
                    k_d    = LenOne;
                end
                if (len_q >= LenTwo) begin
                    state_d = StRead;
                end else if (len_q == LenOne) begin
                    state_d = StDrain;
                end else begin
                    state_d = StCapt;
                end
            end
            StRead: begin
                // Issue element k while the MAC consumes element k-1 returned this cycle.
                ren     = 1'b1;
                addr_a  = base_a_q + k_q[ADDR_W-1:0];
                addr_b  = base_b_q + k_q[ADDR_W-1:0];
                mac_in1 = rdata_a;
                mac_in2 = rdata_b;
                k_d     = k_q + LenOne;
                if (k_q == len_q - LenOne) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                mac_in1 = rdata_a;
                mac_in2 = rdata_b;
                state_d = StCapt;
            end
            StCapt: begin
                result_d = mac_acc;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Cancel wins over everything, including a capture in progress.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            len_q    <= len_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign result = result_q;

endmodule
